branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage branch resolution block, paired with the gshare predictor.
- Fetch pushes each fetched instruction's PC and prediction into an in-order in-flight queue; EX pops the oldest entry when the instruction resolves.
- Compares prediction with actual outcome; produces the redirect/flush to fetch and the registered predictor update strobe (branch/taken/pc/target).
- Keeps branch and mispredict statistics counters.

Parameters:
DEPTH, 4, in-flight queue entries (power of two, >=2)
CNT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
fetchValid  in  1  fetched instruction presented for push
fetchPc  in  32  PC of fetched instruction
fetchPredTaken  in  1  predictor hit/taken for this PC
fetchPredTarget  in  32  predicted target
fetchReady  out  1  queue can accept push (count < DEPTH)
exValid  in  1  oldest instruction resolves this cycle (pop)
exIsBranch  in  1  resolving instruction is a branch/jump
exActualTaken  in  1  actual direction (ignored if !exIsBranch)
exActualTarget  in  32  actual target (ignored if not taken)
redirectValid  out  1  one-cycle flush/redirect pulse to fetch
redirectPc  out  32  correct next PC
bpBranch  out  1  predictor update strobe (drives exBranch)
bpTaken  out  1  update direction
bpPc  out  32  update PC
bpTarget  out  32  update target
branchCount  out  CNT_WIDTH  resolved branches
mispredictCount  out  CNT_WIDTH  mispredicts (all causes)
underflowErr  out  1  sticky: exValid with empty queue

Behaviour:
- Reset (async, rst=0): queue empty, read/write pointers 0, all outputs 0; fetchReady=1 once reset released.
- Queue: circular buffer of {pc, predTaken, predTarget}, log2(DEPTH)-bit pointers plus occupancy counter 0..DEPTH. fetchReady = (count != DEPTH), from registered state only.
- Push accepted when fetchValid && fetchReady. Pop when exValid && count != 0. Full queue: push refused even if a pop occurs the same cycle. Push and pop in the same cycle on a non-full, non-empty queue: count unchanged.
- Resolution, combinational on the head entry E:
  - Branch, mispredict if predTaken != actualTaken, or both taken and predTarget != actualTarget.
  - Non-branch, mispredict if predTaken=1.
  - correctPc = (branch && actualTaken) ? actualTarget : E.pc + 32'd4 (modulo 2^32).
- Mispredict: flush. Pointers reset to 0 and count to 0 in the same edge. A push presented in the flush cycle is dropped.
- Outputs are registered, one-cycle latency from the pop edge:
  - redirectValid=1 for exactly one cycle, with redirectPc=correctPc. Otherwise redirectValid=0 and redirectPc holds its last value.
  - bpBranch=1 for one cycle for every popped branch, mispredicted or not, with bpTaken, bpPc=E.pc, bpTarget=actualTarget. bpBranch=0 for non-branches.
- Counters:
  - branchCount += 1 per popped branch.
  - mispredictCount += 1 per mispredict, including non-branch false-taken.
  - Both wrap modulo 2^CNT_WIDTH.
- exValid with empty queue: no pop, no outputs, underflowErr set; it stays set until reset.
- Reset mid-operation: all in-flight entries discarded immediately; pending redirect/update pulses cancelled.

Test Plan:
- Push pc=0x100 pred not-taken; pop as branch taken, target 0x200 -> next cycle redirectValid=1, redirectPc=0x200, bpBranch=1, bpTaken=1, bpPc=0x100, bpTarget=0x200; mispredictCount=1, branchCount=1, queue empty.
- Push pc=0x40 pred taken 0x80; pop as branch taken 0x84 -> target mismatch: redirectPc=0x84, mispredictCount increments.
- Push pc=0x10 pred taken 0x30; pop as non-branch -> redirectPc=0x14, bpBranch=0, branchCount unchanged.
- Push 4 correct predictions with no pops -> fetchReady=0 after the 4th. Fifth push with a simultaneous pop is refused; after 4 pops, bpPc follows FIFO order and no redirect occurs.
- Push 3 entries, mispredict on the oldest while pushing a 4th -> queue empty after the edge and the 4th push is dropped; the next exValid sets underflowErr=1.
- Assert rst=0 asynchronously with 2 entries queued and an update pending -> outputs go to 0 immediately and fetchReady=1 after release; at 0xFFFFFFFF, a further mispredict wraps mispredictCount to 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: in-order queue of fetch-time predictions, checked against
// actual outcomes to produce the fetch redirect, the predictor update strobe and statistics.
module branch_resolve_unit #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetchValid,
  input  logic [31:0]          fetchPc,
  input  logic                 fetchPredTaken,
  input  logic [31:0]          fetchPredTarget,
  output logic                 fetchReady,
  input  logic                 exValid,
  input  logic                 exIsBranch,
  input  logic                 exActualTaken,
  input  logic [31:0]          exActualTarget,
  output logic                 redirectValid,
  output logic [31:0]          redirectPc,
  output logic                 bpBranch,
  output logic                 bpTaken,
  output logic [31:0]          bpPc,
  output logic [31:0]          bpTarget,
  output logic [CNT_WIDTH-1:0] branchCount,
  output logic [CNT_WIDTH-1:0] mispredictCount,
  output logic                 underflowErr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCount = DEPTH[PW:0];

  logic [31:0]          memPc_q         [DEPTH];
  logic                 memPredTaken_q  [DEPTH];
  logic [31:0]          memPredTarget_q [DEPTH];

  logic [PW-1:0]        wrPtr_q, wrPtr_d;
  logic [PW-1:0]        rdPtr_q, rdPtr_d;
  logic [PW:0]          count_q, count_d;

  logic                 redirectValid_q, redirectValid_d;
  logic [31:0]          redirectPc_q, redirectPc_d;
  logic                 bpBranch_q, bpBranch_d;
  logic                 bpTaken_q, bpTaken_d;
  logic [31:0]          bpPc_q, bpPc_d;
  logic [31:0]          bpTarget_q, bpTarget_d;
  logic [CNT_WIDTH-1:0] branchCount_q, branchCount_d;
  logic [CNT_WIDTH-1:0] mispredictCount_q, mispredictCount_d;
  logic                 underflowErr_q, underflowErr_d;

  logic                 popEn, pushEn, mispredict, flush, popBranch;
  logic [31:0]          headPc, headPredTarget, correctPc;
  logic                 headPredTaken;

  assign fetchReady     = (count_q != FullCount);
  assign headPc         = memPc_q[rdPtr_q];
  assign headPredTaken  = memPredTaken_q[rdPtr_q];
  assign headPredTarget = memPredTarget_q[rdPtr_q];

  // Resolve the head entry; a mispredict flushes the whole queue including any same-cycle push.
  always_comb begin
    popEn      = exValid && (count_q != '0);
    popBranch  = popEn && exIsBranch;
    mispredict = 1'b0;
    if (exIsBranch) begin
      mispredict = (headPredTaken != exActualTaken) ||
                   (headPredTaken && exActualTaken && (headPredTarget != exActualTarget));
    end else begin
      mispredict = headPredTaken;
    end
    flush     = popEn && mispredict;
    pushEn    = fetchValid && fetchReady && !flush;
    correctPc = (exIsBranch && exActualTaken) ? exActualTarget : headPc + 32'd4;
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushEn) wrPtr_d = wrPtr_q + PW'(1);
      if (popEn)  rdPtr_d = rdPtr_q + PW'(1);
      case ({pushEn, popEn})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pulses last one cycle; the accompanying data holds its last value between pulses.
  always_comb begin
    redirectValid_d   = flush;
    redirectPc_d      = flush ? correctPc : redirectPc_q;
    bpBranch_d        = popBranch;
    bpTaken_d         = popBranch ? exActualTaken  : bpTaken_q;
    bpPc_d            = popBranch ? headPc         : bpPc_q;
    bpTarget_d        = popBranch ? exActualTarget : bpTarget_q;
    branchCount_d     = branchCount_q + CNT_WIDTH'(popBranch);
    mispredictCount_d = mispredictCount_q + CNT_WIDTH'(flush);
    underflowErr_d    = underflowErr_q || (exValid && (count_q == '0));
  end

  always_ff @(posedge clk) begin
    if (pushEn) begin
      memPc_q[wrPtr_q]         <= fetchPc;
      memPredTaken_q[wrPtr_q]  <= fetchPredTaken;
      memPredTarget_q[wrPtr_q] <= fetchPredTarget;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q           <= '0;
      rdPtr_q           <= '0;
      count_q           <= '0;
      redirectValid_q   <= 1'b0;
      redirectPc_q      <= '0;
      bpBranch_q        <= 1'b0;
      bpTaken_q         <= 1'b0;
      bpPc_q            <= '0;
      bpTarget_q        <= '0;
      branchCount_q     <= '0;
      mispredictCount_q <= '0;
      underflowErr_q    <= 1'b0;
    end else begin
      wrPtr_q           <= wrPtr_d;
      rdPtr_q           <= rdPtr_d;
      count_q           <= count_d;
      redirectValid_q   <= redirectValid_d;
      redirectPc_q      <= redirectPc_d;
      bpBranch_q        <= bpBranch_d;
      bpTaken_q         <= bpTaken_d;
      bpPc_q            <= bpPc_d;
      bpTarget_q        <= bpTarget_d;
      branchCount_q     <= branchCount_d;
      mispredictCount_q <= mispredictCount_d;
      underflowErr_q    <= underflowErr_d;
    end
  end

  assign redirectValid   = redirectValid_q;
  assign redirectPc      = redirectPc_q;
  assign bpBranch        = bpBranch_q;
  assign bpTaken         = bpTaken_q;
  assign bpPc            = bpPc_q;
  assign bpTarget        = bpTarget_q;
  assign branchCount     = branchCount_q;
  assign mispredictCount = mispredictCount_q;
  assign underflowErr    = underflowErr_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a table of per-cycle vectors plus hand-written
// sequences for asynchronous reset and counter wrap (counters narrowed to 4 bits).
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetchValid, fetchPredTaken, exValid, exIsBranch, exActualTaken;
  logic [31:0]   fetchPc, fetchPredTarget, exActualTarget;
  logic          fetchReady, redirectValid, bpBranch, bpTaken, underflowErr;
  logic [31:0]   redirectPc, bpPc, bpTarget;
  logic [CW-1:0] branchCount, mispredictCount;

  int nVectors     = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .fetchValid(fetchValid), .fetchPc(fetchPc), .fetchPredTaken(fetchPredTaken),
    .fetchPredTarget(fetchPredTarget), .fetchReady(fetchReady),
    .exValid(exValid), .exIsBranch(exIsBranch), .exActualTaken(exActualTaken),
    .exActualTarget(exActualTarget),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .bpBranch(bpBranch), .bpTaken(bpTaken), .bpPc(bpPc), .bpTarget(bpTarget),
    .branchCount(branchCount), .mispredictCount(mispredictCount),
    .underflowErr(underflowErr)
  );

  typedef struct {
    logic          fv;
    logic [31:0]   fpc;
    logic          fpt;
    logic [31:0]   fptgt;
    logic          ev;
    logic          eb;
    logic          eat;
    logic [31:0]   eatgt;
    logic          xReady;
    logic          xRv;
    logic [31:0]   xRpc;
    logic          xBpB;
    logic          xBpT;
    logic [31:0]   xBpPc;
    logic [31:0]   xBpTgt;
    logic [CW-1:0] xBr;
    logic [CW-1:0] xMp;
    logic          xUf;
  } vec_t;

  vec_t vecs [19];

  task automatic drive(input logic fv, input logic [31:0] fpc, input logic fpt,
                       input logic [31:0] fptgt, input logic ev, input logic eb,
                       input logic eat, input logic [31:0] eatgt);
    fetchValid = fv; fetchPc = fpc; fetchPredTaken = fpt; fetchPredTarget = fptgt;
    exValid = ev; exIsBranch = eb; exActualTaken = eat; exActualTarget = eatgt;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.fv, v.fpc, v.fpt, v.fptgt, v.ev, v.eb, v.eat, v.eatgt);
  endtask

  task automatic cmpField(input int idx, input string name, input logic [31:0] act,
                          input logic [31:0] exp, inout bit bad);
    if (act !== exp) begin
      $display("[TB] FAIL vec%0d %s: got 0x%08h, expected 0x%08h", idx, name, act, exp);
      bad = 1'b1;
    end
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    bit bad = 1'b0;
    cmpField(idx, "fetchReady",      32'(fetchReady),      32'(v.xReady), bad);
    cmpField(idx, "redirectValid",   32'(redirectValid),   32'(v.xRv),    bad);
    cmpField(idx, "redirectPc",      redirectPc,           v.xRpc,        bad);
    cmpField(idx, "bpBranch",        32'(bpBranch),        32'(v.xBpB),   bad);
    cmpField(idx, "bpTaken",         32'(bpTaken),         32'(v.xBpT),   bad);
    cmpField(idx, "bpPc",            bpPc,                 v.xBpPc,       bad);
    cmpField(idx, "bpTarget",        bpTarget,             v.xBpTgt,      bad);
    cmpField(idx, "branchCount",     32'(branchCount),     32'(v.xBr),    bad);
    cmpField(idx, "mispredictCount", 32'(mispredictCount), 32'(v.xMp),    bad);
    cmpField(idx, "underflowErr",    32'(underflowErr),    32'(v.xUf),    bad);
    nVectors++;
    if (bad) nMiscompares++;
  endtask

  task automatic checkSignal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      nMiscompares++;
    end
  endtask

  initial begin
    // fields: fv fpc fpt fptgt | ev eb eat eatgt | ready rv rpc bpB bpT bpPc bpTgt br mp uf
    vecs[0]  = '{1'b1, 32'h100,  1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,    4'd0, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h200,  1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h100,  32'h200,  4'd1, 4'd1, 1'b0};
    vecs[2]  = '{1'b1, 32'h40,   1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 32'h100,  32'h200,  4'd1, 4'd1, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h84,   1'b1, 1'b1, 32'h84,  1'b1, 1'b1, 32'h40,   32'h84,   4'd2, 4'd2, 1'b0};
    vecs[4]  = '{1'b1, 32'h10,   1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h84,  1'b0, 1'b1, 32'h40,   32'h84,   4'd2, 4'd2, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h14,  1'b0, 1'b1, 32'h40,   32'h84,   4'd2, 4'd3, 1'b0};
    vecs[6]  = '{1'b1, 32'h1000, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h14,  1'b0, 1'b1, 32'h40,   32'h84,   4'd2, 4'd3, 1'b0};
    vecs[7]  = '{1'b1, 32'h2000, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h14,  1'b0, 1'b1, 32'h40,   32'h84,   4'd2, 4'd3, 1'b0};
    vecs[8]  = '{1'b1, 32'h3000, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h14,  1'b0, 1'b1, 32'h40,   32'h84,   4'd2, 4'd3, 1'b0};
    vecs[9]  = '{1'b1, 32'h4000, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h14,  1'b0, 1'b1, 32'h40,   32'h84,   4'd2, 4'd3, 1'b0};
    vecs[10] = '{1'b1, 32'h5000, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h1008, 1'b1, 1'b0, 32'h14,  1'b1, 1'b0, 32'h1000, 32'h1008, 4'd3, 4'd3, 1'b0};
    vecs[11] = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h14,  1'b0, 1'b0, 32'h1000, 32'h1008, 4'd3, 4'd3, 1'b0};
    vecs[12] = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 32'h14,  1'b1, 1'b0, 32'h3000, 32'h0,    4'd4, 4'd3, 1'b0};
    vecs[13] = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 32'h14,  1'b1, 1'b0, 32'h4000, 32'h0,    4'd5, 4'd3, 1'b0};
    vecs[14] = '{1'b1, 32'h500,  1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h14,  1'b0, 1'b0, 32'h4000, 32'h0,    4'd5, 4'd3, 1'b0};
    vecs[15] = '{1'b1, 32'h504,  1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h14,  1'b0, 1'b0, 32'h4000, 32'h0,    4'd5, 4'd3, 1'b0};
    vecs[16] = '{1'b1, 32'h508,  1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h14,  1'b0, 1'b0, 32'h4000, 32'h0,    4'd5, 4'd3, 1'b0};
    vecs[17] = '{1'b1, 32'h50C,  1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h600,  1'b1, 1'b1, 32'h600, 1'b1, 1'b1, 32'h500,  32'h600,  4'd6, 4'd4, 1'b0};
    vecs[18] = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h600, 1'b0, 1'b1, 32'h500,  32'h600,  4'd6, 4'd4, 1'b1};

    fetchValid = 1'b0; fetchPc = '0; fetchPredTaken = 1'b0; fetchPredTarget = '0;
    exValid = 1'b0; exIsBranch = 1'b0; exActualTaken = 1'b0; exActualTarget = '0;

    repeat (2) @(posedge clk);
    #1;
    checkSignal("reset redirectValid", 32'(redirectValid), 32'h0);
    checkSignal("reset bpBranch", 32'(bpBranch), 32'h0);
    checkSignal("reset mispredictCount", 32'(mispredictCount), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkSignal("post-reset fetchReady", 32'(fetchReady), 32'h1);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Two entries left queued with an update strobe outstanding, then reset mid-cycle.
    drive(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h704, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h708, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkSignal("pending bpBranch", 32'(bpBranch), 32'h1);
    checkSignal("pending bpPc", bpPc, 32'h700);
    exValid = 1'b0; exIsBranch = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkSignal("async reset bpBranch", 32'(bpBranch), 32'h0);
    checkSignal("async reset bpPc", bpPc, 32'h0);
    checkSignal("async reset redirectPc", redirectPc, 32'h0);
    checkSignal("async reset branchCount", 32'(branchCount), 32'h0);
    checkSignal("async reset underflowErr", 32'(underflowErr), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkSignal("release fetchReady", 32'(fetchReady), 32'h1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkSignal("entries discarded underflowErr", 32'(underflowErr), 32'h1);
    checkSignal("entries discarded bpBranch", 32'(bpBranch), 32'h0);

    // Drive the narrowed counters to all-ones, then one more mispredict wraps them.
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 32'h800 + 32'(i) * 32'd4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h900);
    end
    checkSignal("counter max mispredictCount", 32'(mispredictCount), 32'hF);
    checkSignal("counter max branchCount", 32'(branchCount), 32'hF);
    drive(1'b1, 32'h880, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h904);
    checkSignal("wrap mispredictCount", 32'(mispredictCount), 32'h0);
    checkSignal("wrap branchCount", 32'(branchCount), 32'h0);
    checkSignal("wrap redirectPc", redirectPc, 32'h904);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkSignal("redirect single pulse", 32'(redirectValid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
